pipeline_stall_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline. It merges three event sources into one set of pipeline control signals:
- load-use hazard detection;
- taken-branch flush of IF/ID;
- multi-cycle stall for the iterative mult/div unit.

It sits beside the ID stage and drives the PC load, IF/ID load, IF/ID flush and the ID/EX control-bubble mux select.

---
 rtl/pipeline_stall_controller_if.sv | 47 ++++
 rtl/pipeline_stall_controller.sv | 125 ++++++++++++
 tb/tb_pipeline_stall_controller.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_stall_controller_if
//  Description : Bundle of hazard inputs and pipeline control outputs shared
//                between the ID-stage stall controller and the pipeline.
//                master : the stall controller (drives PC/IF/ID/bubble controls)
//                slave  : the pipeline side (drives hazard/event inputs)
//                Optional macro HAZARD_STATS_EN adds stall_count/flush_count.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_stall_controller_if;
    // Hazard / event inputs to the controller
    logic        IDEX_mem_read;
    logic [4:0]  IDEX_Rt;
    logic [4:0]  IFID_Rs;
    logic [4:0]  IFID_Rt;
    logic        md_req;
    logic        branch_taken;
    // Pipeline controls from the controller
    logic        pc_load;
    logic        IFID_Ld;
    logic        IFID_flush;
    logic        sel_signal;
    logic        md_start;
    logic        md_busy;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count;
    logic [31:0] flush_count;
`endif

    modport master (
        input  IDEX_mem_read, IDEX_Rt, IFID_Rs, IFID_Rt, md_req, branch_taken,
        output pc_load, IFID_Ld, IFID_flush, sel_signal, md_start, md_busy
`ifdef HAZARD_STATS_EN
        , output stall_count, flush_count
`endif
    );

    modport slave (
        output IDEX_mem_read, IDEX_Rt, IFID_Rs, IFID_Rt, md_req, branch_taken,
        input  pc_load, IFID_Ld, IFID_flush, sel_signal, md_start, md_busy
`ifdef HAZARD_STATS_EN
        , input stall_count, flush_count
`endif
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_stall_controller
//  Description : Stall/flush sequencer for a 5-stage MIPS pipeline. Merges
//                load-use hazards, taken-branch IF/ID flush and the
//                multi-cycle mult/div stall into PC load, IF/ID load,
//                IF/ID flush and ID/EX bubble-select controls.
//  Ports       : clk  - pipeline clock
//                rst  - synchronous active-high reset
//                bus  - pipeline_stall_controller_if.master (hazard inputs,
//                       control outputs, optional statistics)
//  Parameters  : MD_LATENCY - mult/div cycles from md_start to result (2..255)
//  Options     : HAZARD_STATS_EN - adds 32-bit stall_count / flush_count
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_controller #(
    parameter int MD_LATENCY = 32
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    pipeline_stall_controller_if.master bus
);
    localparam int CNT_W = $clog2(MD_LATENCY + 1);
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(MD_LATENCY - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MD_WAIT    = 2'd1,
        MD_RELEASE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_lu;

    // A destination of $0 still counts: conservative, never misses a hazard.
    assign w_lu = bus.IDEX_mem_read &&
                  ((bus.IDEX_Rt == bus.IFID_Rs) || (bus.IDEX_Rt == bus.IFID_Rt));

    always_comb begin
        bus.pc_load    = 1'b1;
        bus.IFID_Ld    = 1'b1;
        bus.IFID_flush = 1'b0;
        bus.sel_signal = 1'b1;
        bus.md_start   = 1'b0;
        bus.md_busy    = 1'b0;
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;

        if (!rst) begin
            case (r_state)
                RUN: begin
                    if (w_lu) begin
                        bus.pc_load    = 1'b0;
                        bus.IFID_Ld    = 1'b0;
                        bus.sel_signal = 1'b0;
                    end else if (bus.md_req) begin
                        // The start cycle is the first of MD_LATENCY stalled cycles.
                        bus.md_start   = 1'b1;
                        bus.md_busy    = 1'b1;
                        bus.pc_load    = 1'b0;
                        bus.IFID_Ld    = 1'b0;
                        bus.sel_signal = 1'b0;
                        w_cnt_nxt      = C_CNT_LOAD;
                        w_state_nxt    = MD_WAIT;
                    end else if (bus.branch_taken) begin
                        bus.IFID_flush = 1'b1;
                    end
                end
                MD_WAIT: begin
                    bus.pc_load    = 1'b0;
                    bus.IFID_Ld    = 1'b0;
                    bus.sel_signal = 1'b0;
                    bus.md_busy    = 1'b1;
                    w_cnt_nxt      = (r_cnt != '0) ? (r_cnt - C_CNT_ONE) : '0;
                    if (r_cnt <= C_CNT_ONE) begin
                        w_state_nxt = MD_RELEASE;
                    end
                end
                MD_RELEASE: begin
                    // Held mult advances to EX; md_req ignored so it does not restart.
                    w_cnt_nxt   = '0;
                    w_state_nxt = RUN;
                end
                default: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_count;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (!bus.pc_load)   r_stall_count <= r_stall_count + 32'd1;
            if (bus.IFID_flush) r_flush_count <= r_flush_count + 32'd1;
        end
    end

    assign bus.stall_count = r_stall_count;
    assign bus.flush_count = r_flush_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_stall_controller
//  Description : Directed self-checking bench. Two controllers share one
//                stimulus stream: MD_LATENCY=4 and MD_LATENCY=8. Outputs are
//                compared as {pc_load, IFID_Ld, IFID_flush, sel_signal,
//                md_start, md_busy}. Statistics checks compile only when
//                HAZARD_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    pipeline_stall_controller_if if4 ();
    pipeline_stall_controller_if if8 ();

    pipeline_stall_controller #(.MD_LATENCY(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    pipeline_stall_controller #(.MD_LATENCY(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

    always #5 clk = ~clk;

    logic [5:0] o4, o8;
    assign o4 = {if4.pc_load, if4.IFID_Ld, if4.IFID_flush, if4.sel_signal, if4.md_start, if4.md_busy};
    assign o8 = {if8.pc_load, if8.IFID_Ld, if8.IFID_flush, if8.sel_signal, if8.md_start, if8.md_busy};

    localparam logic [5:0] C_DEF   = 6'b110100;
    localparam logic [5:0] C_STALL = 6'b000000;
    localparam logic [5:0] C_START = 6'b000011;
    localparam logic [5:0] C_WAIT  = 6'b000001;
    localparam logic [5:0] C_FLUSH = 6'b111100;

    // Apply one cycle of inputs just after the falling edge, settle 1 time unit.
    task automatic drv(input logic r, input logic mr, input logic [4:0] xrt,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic md, input logic br);
        @(negedge clk);
        rst = r;
        if4.IDEX_mem_read = mr; if8.IDEX_mem_read = mr;
        if4.IDEX_Rt = xrt;      if8.IDEX_Rt = xrt;
        if4.IFID_Rs = rs;       if8.IFID_Rs = rs;
        if4.IFID_Rt = rt;       if8.IFID_Rt = rt;
        if4.md_req = md;        if8.md_req = md;
        if4.branch_taken = br;  if8.branch_taken = br;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        // Reset: outputs forced to defaults despite hazard/mult/branch inputs
        drv(1, 1, 5'd8, 5'd8, 5'd3, 1, 1);
        chk("reset_outs4", 32'(o4), 32'(C_DEF));
        chk("reset_outs8", 32'(o8), 32'(C_DEF));
        drv(1, 0, 5'd0, 5'd1, 5'd2, 0, 0);

        // Load-use has priority over md_req and branch_taken
        drv(0, 1, 5'd8, 5'd8, 5'd3, 1, 1);
        chk("lu_rs_priority", 32'(o4), 32'(C_STALL));
        drv(0, 0, 5'd0, 5'd1, 5'd2, 0, 0);
        chk("lu_cleared", 32'(o4), 32'(C_DEF));
        // Match on rt with destination $0 still stalls
        drv(0, 1, 5'd0, 5'd5, 5'd0, 0, 0);
        chk("lu_rt_zero", 32'(o4), 32'(C_STALL));
        // Matching registers without a load is not a hazard
        drv(0, 0, 5'd9, 5'd9, 5'd9, 0, 0);
        chk("no_load_no_lu", 32'(o4), 32'(C_DEF));

        // Branch flush for exactly the cycle it is taken
        drv(0, 0, 5'd0, 5'd1, 5'd2, 0, 1);
        chk("branch_flush", 32'(o4), 32'(C_FLUSH));
        drv(0, 0, 5'd0, 5'd1, 5'd2, 0, 0);
        chk("branch_after", 32'(o4), 32'(C_DEF));

        // Mult stall (latency 4): start, 3 waits ignoring lu/branch, release
        drv(0, 0, 5'd0, 5'd1, 5'd2, 1, 0);
        chk("md_start", 32'(o4), 32'(C_START));
        drv(0, 0, 5'd0, 5'd1, 5'd2, 1, 0);
        chk("md_wait1", 32'(o4), 32'(C_WAIT));
        drv(0, 0, 5'd0, 5'd1, 5'd2, 1, 1);
        chk("md_wait2_branch_ignored", 32'(o4), 32'(C_WAIT));
        drv(0, 1, 5'd1, 5'd1, 5'd2, 1, 0);
        chk("md_wait3_lu_ignored", 32'(o4), 32'(C_WAIT));
        // Release: md_req still high and lu present, neither acted on
        drv(0, 1, 5'd1, 5'd1, 5'd2, 1, 1);
        chk("md_release", 32'(o4), 32'(C_DEF));
        // Back-to-back: request seen in RUN right after release
        drv(0, 0, 5'd0, 5'd1, 5'd2, 1, 0);
        chk("md_b2b_start", 32'(o4), 32'(C_START));
        for (int i = 0; i < 3; i++) begin
            drv(0, 0, 5'd0, 5'd1, 5'd2, 0, 0);
            chk("md_b2b_wait", 32'(o4), 32'(C_WAIT));
        end
        drv(0, 0, 5'd0, 5'd1, 5'd2, 0, 0);
        chk("md_b2b_release", 32'(o4), 32'(C_DEF));

        // Load-use together with md_req: stall first, start on the next cycle
        drv(0, 1, 5'd4, 5'd4, 5'd2, 1, 0);
        chk("lu_md_stall", 32'(o4), 32'(C_STALL));
        drv(0, 0, 5'd4, 5'd4, 5'd2, 1, 0);
        chk("lu_md_start", 32'(o4), 32'(C_START));
        for (int i = 0; i < 3; i++) begin
            drv(0, 0, 5'd0, 5'd1, 5'd2, 1, 0);
            chk("lu_md_wait", 32'(o4), 32'(C_WAIT));
        end
        drv(0, 0, 5'd0, 5'd1, 5'd2, 1, 0);
        chk("lu_md_release", 32'(o4), 32'(C_DEF));

        // Reset during MD_WAIT (latency 8), then a full 8-cycle stall
        drv(1, 0, 5'd0, 5'd1, 5'd2, 0, 0);
        drv(0, 0, 5'd0, 5'd1, 5'd2, 1, 0);
        chk("rst_mid_start", 32'(o8), 32'(C_START));
        drv(0, 0, 5'd0, 5'd1, 5'd2, 0, 0);
        chk("rst_mid_wait1", 32'(o8), 32'(C_WAIT));
        drv(1, 0, 5'd0, 5'd1, 5'd2, 0, 0);
        chk("rst_mid_forced", 32'(o8), 32'(C_DEF));
        drv(0, 0, 5'd0, 5'd1, 5'd2, 0, 0);
        chk("rst_mid_after", 32'(o8), 32'(C_DEF));
        drv(0, 0, 5'd0, 5'd1, 5'd2, 1, 0);
        chk("rst_new_start", 32'(o8), 32'(C_START));
        for (int i = 0; i < 7; i++) begin
            drv(0, 0, 5'd0, 5'd1, 5'd2, 1, 0);
            chk("rst_new_wait", 32'(o8), 32'(C_WAIT));
        end
        drv(0, 0, 5'd0, 5'd1, 5'd2, 1, 0);
        chk("rst_new_release", 32'(o8), 32'(C_DEF));

`ifdef HAZARD_STATS_EN
        // One mult (4 stalled cycles) and two branch flushes
        drv(1, 0, 5'd0, 5'd1, 5'd2, 0, 0);
        drv(0, 0, 5'd0, 5'd1, 5'd2, 1, 0);
        for (int i = 0; i < 4; i++) drv(0, 0, 5'd0, 5'd1, 5'd2, 0, 0);
        drv(0, 0, 5'd0, 5'd1, 5'd2, 0, 1);
        drv(0, 0, 5'd0, 5'd1, 5'd2, 0, 0);
        drv(0, 0, 5'd0, 5'd1, 5'd2, 0, 1);
        drv(0, 0, 5'd0, 5'd1, 5'd2, 0, 0);
        chk("stall_count", if4.stall_count, 32'd4);
        chk("flush_count", if4.flush_count, 32'd2);
        drv(1, 0, 5'd0, 5'd1, 5'd2, 0, 0);
        drv(0, 0, 5'd0, 5'd1, 5'd2, 0, 0);
        chk("stall_count_rst", if4.stall_count, 32'd0);
        chk("flush_count_rst", if4.flush_count, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
